// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: length-prefixed PT memory -> ARC4(init, KSA, PRGA) -> length-prefixed CT memory.
// Optional macro ARC4_DROP_EN discards DROP_N keystream bytes between KSA and the first ciphertext byte.
module arc4_encrypt #(
  parameter int unsigned KEY_LEN = 3,
  parameter int unsigned DROP_N  = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic                 rdy,
  input  logic [8*KEY_LEN-1:0] key,
  output logic [7:0]           pt_addr,
  input  logic [7:0]           pt_rddata,
  output logic [7:0]           ct_addr,
  output logic [7:0]           ct_wrdata,
  output logic                 ct_wren,
  output logic [7:0]           s_addr,
  output logic [7:0]           s_wrdata,
  output logic                 s_wren,
  input  logic [7:0]           s_rddata
);

  localparam int unsigned KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int unsigned DW = 9;
`ifdef ARC4_DROP_EN
  localparam bit DROP_ON = 1'b1;
`else
  localparam bit DROP_ON = 1'b0;
`endif
  localparam int unsigned DROP_CNT = DROP_ON ? DROP_N : 0;

  // RD issues a read, WT covers the registered-address latency, the following state consumes the data
  typedef enum logic [4:0] {
    ST_IDLE, ST_INIT,
    ST_KSA_RD_I, ST_KSA_WT_I, ST_KSA_RD_J, ST_KSA_WT_J, ST_KSA_WR_I, ST_KSA_WR_J,
    ST_LEN_RD, ST_LEN_WT, ST_LEN_WR,
    ST_PR_RD_I, ST_PR_WT_I, ST_PR_RD_J, ST_PR_WT_J, ST_PR_WR_I, ST_PR_WR_J,
    ST_PR_RD_K, ST_PR_WT_K, ST_PR_OUT, ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 rdy_q, rdy_d;
  logic [8*KEY_LEN-1:0] key_q, key_d;
  logic [7:0]           i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
  logic [7:0]           si_q, si_d, sj_q, sj_d, pt_q, pt_d;
  logic [KW-1:0]        kidx_q, kidx_d;
  logic [DW-1:0]        drop_q, drop_d;
  logic [7:0]           pt_addr_q, pt_addr_d, ct_addr_q, ct_addr_d, ct_wrdata_q, ct_wrdata_d;
  logic                 ct_wren_q, ct_wren_d, s_wren_q, s_wren_d;
  logic [7:0]           s_addr_q, s_addr_d, s_wrdata_q, s_wrdata_d;
  logic [7:0]           key_byte;
  logic [7:0]           j_ksa, j_prga;

  // Key byte selected by i mod KEY_LEN; byte 0 is the most significant
  always_comb begin
    key_byte = 8'h00;
    for (int unsigned b = 0; b < KEY_LEN; b++) begin
      if (kidx_q == KW'(b)) key_byte = key_q[8*(KEY_LEN-1-b) +: 8];
    end
  end

  assign j_ksa  = j_q + s_rddata + key_byte;
  assign j_prga = j_q + s_rddata;

  always_comb begin
    state_d     = state_q;
    rdy_d       = rdy_q;
    key_d       = key_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    len_d       = len_q;
    si_d        = si_q;
    sj_d        = sj_q;
    pt_d        = pt_q;
    kidx_d      = kidx_q;
    drop_d      = drop_q;
    pt_addr_d   = pt_addr_q;
    ct_addr_d   = ct_addr_q;
    ct_wrdata_d = ct_wrdata_q;
    ct_wren_d   = 1'b0;
    s_addr_d    = s_addr_q;
    s_wrdata_d  = s_wrdata_q;
    s_wren_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rdy_d = 1'b1;
        if (en && rdy_q) begin
          key_d      = key;
          rdy_d      = 1'b0;
          s_addr_d   = 8'h00;
          s_wrdata_d = 8'h00;
          s_wren_d   = 1'b1;
          i_d        = 8'd1;
          j_d        = 8'h00;
          kidx_d     = '0;
          state_d    = ST_INIT;
        end
      end
      ST_INIT: begin
        s_addr_d   = i_q;
        s_wrdata_d = i_q;
        s_wren_d   = 1'b1;
        i_d        = i_q + 8'd1;
        if (i_q == 8'hFF) state_d = ST_KSA_RD_I;
      end
      ST_KSA_RD_I: begin
        s_addr_d = i_q;
        state_d  = ST_KSA_WT_I;
      end
      ST_KSA_WT_I: state_d = ST_KSA_RD_J;
      ST_KSA_RD_J: begin
        si_d     = s_rddata;
        j_d      = j_ksa;
        s_addr_d = j_ksa;
        kidx_d   = (kidx_q == KW'(KEY_LEN - 1)) ? '0 : kidx_q + KW'(1);
        state_d  = ST_KSA_WT_J;
      end
      ST_KSA_WT_J: state_d = ST_KSA_WR_I;
      ST_KSA_WR_I: begin
        s_addr_d   = i_q;
        s_wrdata_d = s_rddata;
        s_wren_d   = 1'b1;
        state_d    = ST_KSA_WR_J;
      end
      ST_KSA_WR_J: begin
        s_addr_d   = j_q;
        s_wrdata_d = si_q;
        s_wren_d   = 1'b1;
        i_d        = i_q + 8'd1;
        state_d    = ST_KSA_RD_I;
        if (i_q == 8'hFF) begin
          j_d = 8'h00;
          if (DROP_CNT != 0) begin
            drop_d  = DW'(DROP_CNT);
            state_d = ST_PR_RD_I;
          end else begin
            state_d = ST_LEN_RD;
          end
        end
      end
      ST_LEN_RD: begin
        pt_addr_d = 8'h00;
        state_d   = ST_LEN_WT;
      end
      ST_LEN_WT: state_d = ST_LEN_WR;
      ST_LEN_WR: begin
        len_d       = pt_rddata;
        ct_addr_d   = 8'h00;
        ct_wrdata_d = pt_rddata;
        ct_wren_d   = 1'b1;
        k_d         = 8'd1;
        state_d     = (pt_rddata == 8'h00) ? ST_DONE : ST_PR_RD_I;
      end
      // Plaintext byte k is fetched alongside S[i]; the PT memory is separate from S
      ST_PR_RD_I: begin
        i_d       = i_q + 8'd1;
        s_addr_d  = i_q + 8'd1;
        pt_addr_d = k_q;
        state_d   = ST_PR_WT_I;
      end
      ST_PR_WT_I: state_d = ST_PR_RD_J;
      ST_PR_RD_J: begin
        si_d     = s_rddata;
        pt_d     = pt_rddata;
        j_d      = j_prga;
        s_addr_d = j_prga;
        state_d  = ST_PR_WT_J;
      end
      ST_PR_WT_J: state_d = ST_PR_WR_I;
      ST_PR_WR_I: begin
        sj_d       = s_rddata;
        s_addr_d   = i_q;
        s_wrdata_d = s_rddata;
        s_wren_d   = 1'b1;
        state_d    = ST_PR_WR_J;
      end
      ST_PR_WR_J: begin
        s_addr_d   = j_q;
        s_wrdata_d = si_q;
        s_wren_d   = 1'b1;
        if (drop_q != '0) begin
          drop_d  = drop_q - DW'(1);
          state_d = (drop_q == DW'(1)) ? ST_LEN_RD : ST_PR_RD_I;
        end else begin
          state_d = ST_PR_RD_K;
        end
      end
      ST_PR_RD_K: begin
        s_addr_d = si_q + sj_q;
        state_d  = ST_PR_WT_K;
      end
      ST_PR_WT_K: state_d = ST_PR_OUT;
      ST_PR_OUT: begin
        ct_addr_d   = k_q;
        ct_wrdata_d = pt_q ^ s_rddata;
        ct_wren_d   = 1'b1;
        k_d         = k_q + 8'd1;
        state_d     = (k_q == len_q) ? ST_DONE : ST_PR_RD_I;
      end
      ST_DONE: begin
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b1;
      key_q       <= '0;
      i_q         <= 8'h00;
      j_q         <= 8'h00;
      k_q         <= 8'h00;
      len_q       <= 8'h00;
      si_q        <= 8'h00;
      sj_q        <= 8'h00;
      pt_q        <= 8'h00;
      kidx_q      <= '0;
      drop_q      <= '0;
      pt_addr_q   <= 8'h00;
      ct_addr_q   <= 8'h00;
      ct_wrdata_q <= 8'h00;
      ct_wren_q   <= 1'b0;
      s_addr_q    <= 8'h00;
      s_wrdata_q  <= 8'h00;
      s_wren_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      key_q       <= key_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      len_q       <= len_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      pt_q        <= pt_d;
      kidx_q      <= kidx_d;
      drop_q      <= drop_d;
      pt_addr_q   <= pt_addr_d;
      ct_addr_q   <= ct_addr_d;
      ct_wrdata_q <= ct_wrdata_d;
      ct_wren_q   <= ct_wren_d;
      s_addr_q    <= s_addr_d;
      s_wrdata_q  <= s_wrdata_d;
      s_wren_q    <= s_wren_d;
    end
  end

  assign rdy       = rdy_q;
  assign pt_addr   = pt_addr_q;
  assign ct_addr   = ct_addr_q;
  assign ct_wrdata = ct_wrdata_q;
  assign ct_wren   = ct_wren_q;
  assign s_addr    = s_addr_q;
  assign s_wrdata  = s_wrdata_q;
  assign s_wren    = s_wren_q;

endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: PT/CT/S memory models, software ARC4 scoreboard, scenario tasks.
module tb_arc4_encrypt;

`ifdef ARC4_DROP_EN
  localparam int DROP = 256;
`else
  localparam int DROP = 0;
`endif
  localparam int BUDGET = 12000;
  localparam logic [23:0] STD_KEY = 24'h4B6579;

  logic        clk = 1'b0;
  logic        rst_n, en, rdy;
  logic [23:0] key;
  logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata, s_addr, s_wrdata, s_rddata;
  logic        ct_wren, s_wren;

  logic [7:0]  pt_mem [256];
  logic [7:0]  s_mem  [256];
  logic [7:0]  ct_mem [256];
  logic [7:0]  std_ct [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

  logic [15:0] exp_q [$];
  logic [15:0] ct_log [$];
  logic [31:0] s_log [$];
  bit          s_log_en = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  arc4_encrypt #(.KEY_LEN(3), .DROP_N(256)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .s_rddata(s_rddata)
  );

  // Memories with registered address / one-cycle read latency
  always @(posedge clk) begin
    if (s_wren) s_mem[s_addr] <= s_wrdata;
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
    if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
  end

  // Capture DUT writes away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (ct_wren === 1'b1) ct_log.push_back({ct_addr, ct_wrdata});
    if (s_log_en && s_wren === 1'b1) s_log.push_back({16'(cyc), s_addr, s_wrdata});
  end

  // Software ARC4 over pt_mem; pushes expected {addr, data} ct writes
  function automatic void arc4_push(input logic [23:0] k, input int drop);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] i, j, t, l;
    kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    j = 8'h00;
    for (int n = 0; n < 256; n++) begin
      j = j + s[n] + kb[n % 3];
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i = 8'h00; j = 8'h00;
    for (int d = 0; d < drop; d++) begin
      i = i + 8'd1; j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    l = pt_mem[0];
    exp_q.push_back({8'h00, l});
    for (int n = 1; n <= int'(l); n++) begin
      i = i + 8'd1; j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      exp_q.push_back({8'(n), pt_mem[n] ^ s[8'(s[i] + s[j])]});
    end
  endfunction

  task automatic load_std_pt();
    logic [7:0] msg [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    for (int n = 0; n < 10; n++) pt_mem[n] = msg[n];
  endtask

  task automatic pulse_en(input logic [23:0] k);
    @(negedge clk);
    key = k;
    en  = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    key = 24'($urandom);
  endtask

  task automatic wait_rdy(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < BUDGET && !ok; n++) begin
      @(negedge clk);
      if (rdy === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; key = 24'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", rdy); end
    checks++;
    if ({ct_wren, s_wren} !== 2'b00) begin
      errors++; $display("FAIL reset_wren: got ct=%b s=%b expected 0 0", ct_wren, s_wren);
    end
    checks++;
    if ({s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata} !== 40'h0) begin
      errors++;
      $display("FAIL reset_bus: got s_addr=%h s_wrdata=%h pt_addr=%h ct_addr=%h ct_wrdata=%h expected all 00",
               s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata);
    end
  endtask

  task automatic test_std_vector();
    bit ok;
    int diffs;
    logic [15:0] got, want;
    load_std_pt();
    exp_q.delete(); ct_log.delete();
    arc4_push(STD_KEY, DROP);
    pulse_en(STD_KEY);
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL std_rdy_drop: got %b expected 0", rdy); end
    wait_rdy(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL std_timeout: got no rdy expected rdy within %0d", BUDGET); end
    checks++;
    if (ct_log.size() != exp_q.size()) begin
      errors++; $display("FAIL std_count: got %0d writes expected %0d", ct_log.size(), exp_q.size());
    end
    while (ct_log.size() > 0 && exp_q.size() > 0) begin
      got = ct_log.pop_front(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL std_model: got %h expected %h", got, want); end
    end
`ifdef ARC4_DROP_EN
    checks++;
    if (ct_mem[0] !== 8'h09) begin errors++; $display("FAIL drop_len: got %h expected 09", ct_mem[0]); end
    diffs = 0;
    for (int n = 1; n < 10; n++) if (ct_mem[n] !== std_ct[n]) diffs++;
    checks++;
    if (diffs == 0) begin errors++; $display("FAIL drop_differs: got %0d differing bytes expected >0", diffs); end
`else
    diffs = 0;
    for (int n = 0; n < 10; n++) begin
      checks++;
      if (ct_mem[n] !== std_ct[n]) begin
        errors++; diffs++;
        $display("FAIL std_const[%0d]: got %h expected %h", n, ct_mem[n], std_ct[n]);
      end
    end
`endif
  endtask

  task automatic test_init_len0();
    bit ok;
    logic [31:0] e;
    logic [15:0] c0;
    logic [23:0] k;
    k = 24'($urandom);
    pt_mem[0] = 8'h00;
    exp_q.delete(); ct_log.delete(); s_log.delete();
    arc4_push(k, DROP);
    s_log_en = 1'b1;
    pulse_en(k);
    wait_rdy(ok);
    s_log_en = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL init_timeout: got no rdy expected rdy within %0d", BUDGET); end
    checks++;
    if (s_log.size() < 256) begin
      errors++; $display("FAIL init_count: got %0d s writes expected >=256", s_log.size());
    end else begin
      c0 = s_log[0][31:16];
      for (int n = 0; n < 256; n++) begin
        e = s_log[n];
        checks++;
        if (e !== {16'(c0 + 16'(n)), 8'(n), 8'(n)}) begin
          errors++;
          $display("FAIL init_write[%0d]: got cyc=%0d addr=%h data=%h expected cyc=%0d addr=data=%h",
                   n, e[31:16], e[15:8], e[7:0], c0 + 16'(n), 8'(n));
        end
      end
    end
    checks++;
    if (ct_log.size() != 1) begin
      errors++; $display("FAIL len0_count: got %0d ct writes expected 1", ct_log.size());
    end
    checks++;
    if (ct_log.size() > 0 && ct_log[0] !== exp_q[0]) begin
      errors++; $display("FAIL len0_ct0: got %h expected %h", ct_log[0], exp_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [15:0] got, want;
    load_std_pt();
    exp_q.delete(); ct_log.delete();
    arc4_push(STD_KEY, DROP);
    arc4_push(STD_KEY, DROP);
    @(negedge clk);
    key = STD_KEY; en = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL busy_accept: got rdy=%b expected 0", rdy); end
    key = 24'hA5C3E1;
    repeat (40) @(negedge clk);
    key = STD_KEY;
    for (int run = 0; run < 2; run++) begin
      wait_rdy(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL busy_timeout[%0d]: got no rdy expected rdy", run); end
      checks++;
      if (ct_log.size() != 10) begin
        errors++; $display("FAIL busy_count[%0d]: got %0d writes expected 10", run, ct_log.size());
      end
      for (int n = 0; n < 10 && ct_log.size() > 0 && exp_q.size() > 0; n++) begin
        got = ct_log.pop_front(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin errors++; $display("FAIL busy_ct[%0d]: got %h expected %h", run, got, want); end
      end
      ct_log.delete();
      @(negedge clk);
      if (run == 0) begin
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL busy_restart: got rdy=%b expected 0", rdy); end
        en = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [15:0] got, want;
    load_std_pt();
    ct_log.delete();
    pulse_en(STD_KEY);
    ok = 1'b0;
    for (int n = 0; n < BUDGET && !ok; n++) begin
      @(negedge clk);
      if (ct_log.size() >= 3) ok = 1'b1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_reach: got %0d ct writes expected 3", ct_log.size()); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({rdy, ct_wren, s_wren} !== 3'b100) begin
      errors++; $display("FAIL rstmid_state: got rdy=%b ct_wren=%b s_wren=%b expected 1 0 0", rdy, ct_wren, s_wren);
    end
    rst_n = 1'b1;
    exp_q.delete(); ct_log.delete();
    arc4_push(STD_KEY, DROP);
    pulse_en(STD_KEY);
    wait_rdy(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_timeout: got no rdy expected rdy"); end
    checks++;
    if (ct_log.size() != exp_q.size()) begin
      errors++; $display("FAIL rstmid_count: got %0d expected %0d", ct_log.size(), exp_q.size());
    end
    while (ct_log.size() > 0 && exp_q.size() > 0) begin
      got = ct_log.pop_front(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL rstmid_ct: got %h expected %h", got, want); end
    end
  endtask

  task automatic test_full_len();
    bit ok;
    logic [23:0] k;
    logic [15:0] got, want;
    k = 24'($urandom);
    pt_mem[0] = 8'hFF;
    for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom);
    exp_q.delete(); ct_log.delete();
    arc4_push(k, DROP);
    pulse_en(k);
    wait_rdy(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_timeout: got no rdy expected rdy"); end
    checks++;
    if (ct_log.size() != 256) begin
      errors++; $display("FAIL full_count: got %0d writes expected 256", ct_log.size());
    end
    while (ct_log.size() > 0 && exp_q.size() > 0) begin
      got = ct_log.pop_front(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL full_ct: got %h expected %h", got, want); end
    end
  endtask

  initial begin
    test_reset();
    test_std_vector();
    test_init_len0();
    test_back_to_back();
    test_reset_mid();
    test_full_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
